// File: rtl/sh7604_bsc_lite.sv
// sh7604_bsc_lite: bus state controller behind the SH7604 DMAC.
// Converts each DBUS request into an external memory cycle
// (T1 address, TW wait, T2 data), with a programmable wait count and
// MEM_RDY extension. Supports single transfers and 4-longword wrapping bursts.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   CE_R                rising-phase clock enable; state advances only when 1
//   DBUS_A/DO/BA/WE     requester address, write data, byte enables, write
//   DBUS_REQ/BURST/LOCK request, 4-beat burst, keep bus (no TH)
//   DBUS_DI             registered read data
//   DBUS_WAIT           stall to requester
//   BSC_ACK             data-phase strobe (high in T2)
//   MEM_A/DO/BE/WE/REQ  external cycle outputs
//   MEM_DI, MEM_RDY     external read data and ready
//   DBG_STATE, DBG_LOCK FSM state and lock flag for observation
//
// Handshake: the requester holds DBUS_REQ and its qualifiers; each beat is
// accepted in the CE_R period where DBUS_WAIT=0 (state T2), which is also
// the period BSC_ACK=1. Read data is valid on DBUS_DI in that same period.
module sh7604_bsc_lite #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned BURST_TW    = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic [31:0] DBUS_A,
  input  logic [31:0] DBUS_DO,
  input  logic [3:0]  DBUS_BA,
  input  logic        DBUS_WE,
  input  logic        DBUS_REQ,
  input  logic        DBUS_BURST,
  input  logic        DBUS_LOCK,
  output logic [31:0] DBUS_DI,
  output logic        DBUS_WAIT,
  output logic        BSC_ACK,
  output logic [31:0] MEM_A,
  output logic [31:0] MEM_DO,
  output logic [3:0]  MEM_BE,
  output logic        MEM_WE,
  output logic        MEM_REQ,
  input  logic [31:0] MEM_DI,
  input  logic        MEM_RDY,
  output logic [2:0]  DBG_STATE,
  output logic        DBG_LOCK
);

  typedef enum logic [2:0] {
    S_TI = 3'd0,
    S_T1 = 3'd1,
    S_TW = 3'd2,
    S_T2 = 3'd3,
    S_TH = 3'd4
  } bsc_state_t;

  localparam logic [2:0] LP_WAIT = 3'(WAIT_CYCLES);
  localparam logic [2:0] LP_BTW  = 3'(BURST_TW);

  bsc_state_t  r_state;
  bsc_state_t  w_next;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt;
  logic [1:0]  r_beat;
  logic        r_burst;
  logic        r_lock;
  logic        r_we;
  logic [31:0] r_a;
  logic [31:0] r_do;
  logic [3:0]  r_be;
  logic [31:0] r_di;
  logic        w_start;
  logic        w_adv;
  logic        w_lock_set;
  logic        w_cap;

  // The counter is decremented on the edge that enters TW, so a load of N
  // yields exactly N TW periods before MEM_RDY is sampled.
  always_comb begin
    w_next     = r_state;
    w_cnt      = r_cnt;
    w_start    = 1'b0;
    w_adv      = 1'b0;
    w_lock_set = 1'b0;
    case (r_state)
      S_TI: begin
        if (DBUS_REQ) begin
          w_next  = S_T1;
          w_start = 1'b1;
          w_cnt   = LP_WAIT;
        end
      end
      S_T1: begin
        if (r_cnt != 3'd0) begin
          w_next = S_TW;
          w_cnt  = r_cnt - 3'd1;
        end else if (MEM_RDY) begin
          w_next = S_T2;
        end else begin
          w_next = S_TW;
        end
      end
      S_TW: begin
        if (r_cnt != 3'd0) begin
          w_cnt = r_cnt - 3'd1;
        end else if (MEM_RDY) begin
          w_next = S_T2;
        end
      end
      S_T2: begin
        if (r_burst && (r_beat != 2'd3)) begin
          w_adv = 1'b1;
          if (LP_BTW != 3'd0) begin
            w_next = S_TW;
            w_cnt  = LP_BTW - 3'd1;
          end else if (MEM_RDY) begin
            w_next = S_T2;
          end else begin
            w_next = S_TW;
            w_cnt  = 3'd0;
          end
        end else if (DBUS_LOCK) begin
          // Locked: skip TH so the next request starts after a single TI.
          w_next     = S_TI;
          w_lock_set = 1'b1;
        end else begin
          w_next = S_TH;
        end
      end
      S_TH:    w_next = S_TI;
      default: w_next = S_TI;
    endcase
  end

  // Every entry into T2 on a read (first beat or later burst beats) captures.
  assign w_cap = (w_next == S_T2) && !r_we;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_TI;
    end else if (CE_R) begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt   <= 3'd0;
      r_beat  <= 2'd0;
      r_burst <= 1'b0;
      r_lock  <= 1'b0;
      r_we    <= 1'b0;
      r_a     <= 32'd0;
      r_do    <= 32'd0;
      r_be    <= 4'd0;
      r_di    <= 32'd0;
    end else if (CE_R) begin
      r_cnt <= w_cnt;
      if (w_start) begin
        r_a     <= DBUS_A;
        r_be    <= DBUS_BA;
        r_we    <= DBUS_WE;
        r_do    <= DBUS_DO;
        r_burst <= DBUS_BURST;
        r_beat  <= 2'd0;
        r_lock  <= 1'b0;
      end
      if (w_adv) begin
        // Wrap within the 16-byte line; only address bits 3:2 move.
        r_beat    <= r_beat + 2'd1;
        r_a[3:2]  <= r_a[3:2] + 2'd1;
        r_do      <= DBUS_DO;
        r_be      <= DBUS_BA;
      end
      if (w_lock_set) begin
        r_lock <= 1'b1;
      end
      if (w_cap) begin
        r_di <= MEM_DI;
      end
    end
  end

  assign DBUS_DI   = r_di;
  assign DBUS_WAIT = DBUS_REQ && (r_state != S_T2);
  assign BSC_ACK   = (r_state == S_T2);
  assign MEM_REQ   = (r_state == S_T1) || (r_state == S_TW) || (r_state == S_T2);
  assign MEM_A     = r_a;
  assign MEM_DO    = r_do;
  assign MEM_BE    = r_be;
  assign MEM_WE    = r_we;
  assign DBG_STATE = r_state;
  assign DBG_LOCK  = r_lock;

endmodule

// File: tb/tb_sh7604_bsc_lite.sv
// Testbench for sh7604_bsc_lite: directed and randomised transfers with a
// scoreboard of expected beats checked on every BSC_ACK.
module tb_sh7604_bsc_lite;

  localparam logic [2:0] ST_TI = 3'd0;
  localparam logic [2:0] ST_T1 = 3'd1;
  localparam logic [2:0] ST_TW = 3'd2;
  localparam logic [2:0] ST_T2 = 3'd3;
  localparam logic [2:0] ST_TH = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic ce_r;
  always #5 clk = ~clk;

  logic [31:0] dbus_a, dbus_do, dbus_di, mem_a, mem_do, mem_di;
  logic [3:0]  dbus_ba, mem_be;
  logic        dbus_we, dbus_req, dbus_burst, dbus_lock, dbus_wait;
  logic        bsc_ack, mem_we, mem_req, mem_rdy, dbg_lock;
  logic [2:0]  dbg_state;

  sh7604_bsc_lite #(.WAIT_CYCLES(1), .BURST_TW(0)) dut (
    .CLK(clk), .RST(rst), .CE_R(ce_r),
    .DBUS_A(dbus_a), .DBUS_DO(dbus_do), .DBUS_BA(dbus_ba), .DBUS_WE(dbus_we),
    .DBUS_REQ(dbus_req), .DBUS_BURST(dbus_burst), .DBUS_LOCK(dbus_lock),
    .DBUS_DI(dbus_di), .DBUS_WAIT(dbus_wait), .BSC_ACK(bsc_ack),
    .MEM_A(mem_a), .MEM_DO(mem_do), .MEM_BE(mem_be), .MEM_WE(mem_we),
    .MEM_REQ(mem_req), .MEM_DI(mem_di), .MEM_RDY(mem_rdy),
    .DBG_STATE(dbg_state), .DBG_LOCK(dbg_lock)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry: {we, be[3:0], addr[31:0], data[31:0]}
  logic [68:0] exp_q[$];
  logic [68:0] mon_e;
  logic [31:0] last_rd;

  always @(negedge clk) begin
    if (!rst && bsc_ack) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_addr", mem_a, mon_e[63:32]);
        check("ack_we", mem_we, mon_e[68]);
        if (mon_e[68]) begin
          check("ack_do", mem_do, mon_e[31:0]);
          check("ack_be", mem_be, mon_e[67:64]);
        end else begin
          check("ack_di", dbus_di, mon_e[31:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Starts at a negedge with the DUT in TI. Memory holds MEM_RDY low for
  // rdy_delay TW periods after the wait count expires. With lock=1 the task
  // returns at the last T2 with the request still asserted.
  task automatic xfer(input logic [31:0] a, input logic we, input logic [3:0] ba0,
                      input logic [31:0] d0, input logic burst, input int rdy_delay,
                      input logic lock, input logic drop_req);
    logic [31:0] d[4];
    logic [3:0]  b[4];
    logic [1:0]  idx;
    int nb, beats, step_n;
    nb = burst ? 4 : 1;
    d[0] = d0;
    b[0] = ba0;
    for (int k = 1; k < 4; k++) begin
      d[k] = $urandom;
      b[k] = 4'($urandom_range(1, 15));
    end
    for (int k = 0; k < nb; k++) begin
      idx = a[3:2] + 2'(k);
      exp_q.push_back({we, b[k], a[31:4], idx, a[1:0], d[k]});
    end
    dbus_a = a; dbus_we = we; dbus_ba = b[0]; dbus_do = d[0];
    dbus_burst = burst; dbus_lock = lock; dbus_req = 1'b1;
    mem_rdy = 1'b0; mem_di = d[0];
    #1;
    check("wait_ti", dbus_wait, 1'b1);
    beats = 0;
    step_n = 0;
    while (beats < nb && step_n < 40) begin
      @(negedge clk);
      step_n++;
      check("ack_time", bsc_ack, 64'(step_n >= 3 + rdy_delay));
      check("wait", dbus_wait, 64'(dbus_req && (step_n < 3 + rdy_delay)));
      check("mem_req", mem_req, 1'b1);
      if (step_n == 1) begin
        check("t1_state", dbg_state, ST_T1);
        check("t1_lock", dbg_lock, 1'b0);
        check("t1_a", mem_a, a);
        check("t1_we", mem_we, we);
        if (we) begin
          check("t1_do", mem_do, d[0]);
          check("t1_be", mem_be, b[0]);
        end
        // Changes after T1 must not leak into the latched cycle.
        dbus_we = ~we; dbus_ba = ~b[0]; dbus_do = ~d[0];
      end
      mem_rdy = (step_n >= 2 + rdy_delay);
      if (bsc_ack) begin
        beats++;
        if (beats == 1 && drop_req) dbus_req = 1'b0;
        if (beats < nb) begin
          dbus_do = d[beats];
          dbus_ba = b[beats];
          mem_di  = d[beats];
        end else if (!lock) begin
          dbus_req = 1'b0;
        end
      end
    end
    check("beats", beats, nb);
    if (!we) last_rd = d[nb-1];
    check("di_hold", dbus_di, last_rd);
    if (!lock) begin
      @(negedge clk);
      check("th_state", dbg_state, ST_TH);
      check("th_memreq", mem_req, 1'b0);
      check("th_ack", bsc_ack, 1'b0);
      @(negedge clk);
      check("ti_state", dbg_state, ST_TI);
      check("ti_memreq", mem_req, 1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; ce_r = 1'b1;
    dbus_a = '0; dbus_do = '0; dbus_ba = '0; dbus_we = 1'b0;
    dbus_req = 1'b0; dbus_burst = 1'b0; dbus_lock = 1'b0;
    mem_di = '0; mem_rdy = 1'b1; last_rd = '0;
    repeat (2) @(negedge clk);
    check("rst_state", dbg_state, ST_TI);
    check("rst_memreq", mem_req, 1'b0);
    check("rst_ack", bsc_ack, 1'b0);
    check("rst_di", dbus_di, 32'd0);
    check("rst_a", mem_a, 32'd0);
    check("rst_do", mem_do, 32'd0);
    check("rst_be", mem_be, 4'd0);
    check("rst_we", mem_we, 1'b0);
    check("rst_lock", dbg_lock, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single read, single write, burst read, burst write with REQ dropped.
    xfer(32'h0600_0010, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 1'b0);
    xfer(32'h0600_0020, 1'b1, 4'b0011, 32'h1234_5678, 1'b0, 0, 1'b0, 1'b0);
    xfer(32'h0600_001C, 1'b0, 4'hF, 32'hCAFE_0001, 1'b1, 0, 1'b0, 1'b0);
    xfer(32'h0600_0035, 1'b1, 4'hF, 32'hA5A5_5A5A, 1'b1, 1, 1'b0, 1'b1);

    // MEM_RDY held low for 5 TW periods after the count expires.
    xfer(32'h0600_0044, 1'b0, 4'hF, 32'h0BAD_F00D, 1'b0, 5, 1'b0, 1'b0);

    // Locked back-to-back: a single TI between the two cycles.
    xfer(32'h0600_0100, 1'b0, 4'hF, 32'h1111_2222, 1'b0, 0, 1'b1, 1'b0);
    @(negedge clk);
    check("lock_ti_state", dbg_state, ST_TI);
    check("lock_ti_memreq", mem_req, 1'b0);
    check("lock_flag", dbg_lock, 1'b1);
    xfer(32'h0600_0104, 1'b1, 4'hC, 32'h3333_4444, 1'b0, 0, 1'b0, 1'b0);
    xfer(32'h0600_0108, 1'b0, 4'hF, 32'h5555_6666, 1'b0, 0, 1'b0, 1'b0);

    // CE_R low holds the FSM in T1 even with MEM_RDY high.
    exp_q.push_back({1'b0, 4'hF, 32'h0600_0200, 32'h7777_8888});
    dbus_a = 32'h0600_0200; dbus_we = 1'b0; dbus_ba = 4'hF; dbus_burst = 1'b0;
    dbus_lock = 1'b0; dbus_req = 1'b1; mem_rdy = 1'b1; mem_di = 32'h7777_8888;
    @(negedge clk);
    check("ce_t1", dbg_state, ST_T1);
    ce_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ce_hold_state", dbg_state, ST_T1);
      check("ce_hold_memreq", mem_req, 1'b1);
    end
    ce_r = 1'b1;
    @(negedge clk);
    check("ce_tw", dbg_state, ST_TW);
    @(negedge clk);
    check("ce_t2_ack", bsc_ack, 1'b1);
    dbus_req = 1'b0;
    last_rd = 32'h7777_8888;
    repeat (2) @(negedge clk);
    check("ce_ti", dbg_state, ST_TI);

    // Reset during TW of a write abandons the cycle.
    dbus_a = 32'h0600_0300; dbus_we = 1'b1; dbus_ba = 4'hF; dbus_do = 32'hFEED_0000;
    dbus_req = 1'b1; mem_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("prerst_tw", dbg_state, ST_TW);
    #2 rst = 1'b1;
    #1;
    check("arst_state", dbg_state, ST_TI);
    check("arst_memreq", mem_req, 1'b0);
    check("arst_we", mem_we, 1'b0);
    check("arst_di", dbus_di, 32'd0);
    dbus_req = 1'b0;
    @(negedge clk);
    check("arst_ack", bsc_ack, 1'b0);
    rst = 1'b0; mem_rdy = 1'b1; last_rd = '0;
    @(negedge clk);
    xfer(32'h0600_0400, 1'b0, 4'hF, 32'h9999_AAAA, 1'b0, 0, 1'b0, 1'b0);

    // Random transfers.
    for (int i = 0; i < 6; i++) begin
      xfer($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom,
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
